// File: rtl/crc16_frame_tx.sv
// Gen2 reader TX framer: serialises a command MSB-first
// onto a valid/ready bit stream, optionally closing with ~CRC-16.
module crc16_frame_tx #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MAX_BITS-1:0] cmd,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                crc_en,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                bit_out,
  output logic                bit_vld,
  input  logic                bit_rdy,
  output logic                crc_rst,
  output logic                crc_data,
  output logic                crc_vld,
  input  logic [15:0]         crc_val
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    CRC
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [MAX_BITS-1:0] shreg;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len_c;
  logic [3:0]          idx;
  logic                ce_q;
  logic                done_n;
  logic                xfer;

  assign len_c = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;

  // abort wins over a handshake: that bit is treated as never sent
  assign xfer = bit_vld & bit_rdy & ~abort;

  // next-state and done decision
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = PRE;
      end
      PRE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          state_n = DATA;
        end else if (ce_q) begin
          state_n = CRC;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      DATA: begin
        if (abort) begin
          state_n = IDLE;
        end else if (xfer && cnt == LEN_W'(1)) begin
          state_n = ce_q ? CRC : IDLE;
          done_n  = ~ce_q;
        end
      end
      CRC: begin
        if (abort) begin
          state_n = IDLE;
        end else if (xfer && idx == 4'd15) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, shift register, counters and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      idx   <= '0;
      ce_q  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (state == IDLE && start) begin
        shreg <= cmd << (MAX_BITS - 32'(len_c));
        cnt   <= len_c;
        ce_q  <= crc_en;
      end
      if (state == DATA && xfer) begin
        shreg <= shreg << 1;
        cnt   <= cnt - LEN_W'(1);
      end
      if (state == PRE) idx <= '0;
      if (state == CRC && xfer) idx <= idx + 4'd1;
    end
  end

  // outputs decode straight from state so reset clears them at once
  always_comb begin
    busy     = (state != IDLE);
    bit_vld  = (state == DATA) | (state == CRC);
    crc_rst  = (state == PRE);
    crc_data = (state == DATA) & shreg[MAX_BITS-1];
    crc_vld  = (state == DATA) & xfer;
    bit_out  = 1'b0;
    if (state == DATA) bit_out = shreg[MAX_BITS-1];
    if (state == CRC)  bit_out = ~crc_val[4'd15 - idx];
  end

endmodule
